// File: rtl/serial_to_parallel_interface.sv
// Byte-serial receive side of the 3x3 matrix link: gathers 18 bytes (nine 16-bit elements,
// row-major, high byte first) into a shadow buffer and commits whole matrices atomically.
module serial_to_parallel_interface #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  serial_in,
  input  logic        in_valid,
  output logic [15:0] in11,
  output logic [15:0] in12,
  output logic [15:0] in13,
  output logic [15:0] in21,
  output logic [15:0] in22,
  output logic [15:0] in23,
  output logic [15:0] in31,
  output logic [15:0] in32,
  output logic [15:0] in33,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int NUM_BYTES = 18;
  localparam int NUM_ELEM  = 9;
  localparam int IW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [4:0] LAST_BYTE = 5'(NUM_BYTES - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                        state, state_nxt;
  logic [4:0]                    byte_cnt, byte_cnt_nxt;
  logic [IW-1:0]                 idle_cnt, idle_cnt_nxt;
  logic [NUM_BYTES-1:0][7:0]     shadow, shadow_nxt;
  logic [NUM_ELEM-1:0][15:0]     mat;
  logic                          commit, abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    idle_cnt_nxt = idle_cnt;
    shadow_nxt   = shadow;
    commit       = 1'b0;
    abort        = 1'b0;
    case (state)
      IDLE: begin
        idle_cnt_nxt = '0;
        if (in_valid) begin
          shadow_nxt[0] = serial_in;
          byte_cnt_nxt  = 5'd1;
          state_nxt     = RECV;
        end
      end
      RECV: begin
        if (in_valid) begin
          shadow_nxt[byte_cnt] = serial_in;
          idle_cnt_nxt         = '0;
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt_nxt = '0;
            state_nxt    = IDLE;
            commit       = 1'b1;
          end else begin
            byte_cnt_nxt = byte_cnt + 5'd1;
          end
        end else if (TIMEOUT_CYC != 0 && (int'(idle_cnt) + 1) >= TIMEOUT_CYC) begin
          idle_cnt_nxt = '0;
          byte_cnt_nxt = '0;
          state_nxt    = IDLE;
          abort        = 1'b1;
        end else if (idle_cnt != {IW{1'b1}}) begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RECV);
  end

  // The committing edge loads from shadow_nxt so the final byte lands in the same update,
  // giving done and the new matrix on the edge right after the 18th byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      mat    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      done   <= commit;
      err    <= abort;
      if (commit) begin
        for (int e = 0; e < NUM_ELEM; e++)
          mat[e] <= {shadow_nxt[2*e], shadow_nxt[2*e+1]};
      end
    end
  end

  assign in11 = mat[0];
  assign in12 = mat[1];
  assign in13 = mat[2];
  assign in21 = mat[3];
  assign in22 = mat[4];
  assign in23 = mat[5];
  assign in31 = mat[6];
  assign in32 = mat[7];
  assign in33 = mat[8];
endmodule

// File: tb/tb_serial_to_parallel_interface.sv
// Scenario bench for serial_to_parallel_interface: expected matrices are queued as frames
// are driven and compared by a monitor whenever done pulses.
module tb_serial_to_parallel_interface;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  serial_in = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in11, in12, in13, in21, in22, in23, in31, in32, in33;
  logic        busy, done, err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ndone = 0;
  int nerr = 0;
  int busy_cnt = 0;
  int done_cyc = 0;
  int prev_done_cyc = 0;
  logic [143:0] sb[$];
  logic [143:0] last_good = '0;
  logic [143:0] got;

  serial_to_parallel_interface #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
    .in11(in11), .in12(in12), .in13(in13), .in21(in21), .in22(in22), .in23(in23),
    .in31(in31), .in32(in32), .in33(in33), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign got = {in11, in12, in13, in21, in22, in23, in31, in32, in33};

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (err) nerr++;
    if (done && err) begin
      total++; bad++;
      $display("FAIL done_err_overlap at cycle %0d", cyc);
    end
    if (done) begin
      ndone++;
      prev_done_cyc = done_cyc;
      done_cyc = cyc;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done got=%h", got);
      end else begin
        logic [143:0] e;
        e = sb.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL matrix got=%h exp=%h", got, e);
        end
        last_good = e;
      end
    end
  end

  logic [7:0] f1[18] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h11,
                         8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h55, 8'h55};
  logic [7:0] fa[18] = '{default: 8'hAA};
  logic [7:0] fr[18];

  task automatic send_frame(input logic [7:0] b[18], input int gap_at, input int gap_len);
    logic [143:0] e;
    e = '0;
    for (int k = 0; k < 18; k++) begin
      in_valid = 1'b1;
      serial_in = b[k];
      e = {e[135:0], b[k]};
      if (k == 17) sb.push_back(e);
      @(posedge clk); #1;
      if (k == gap_at) begin
        in_valid = 1'b0;
        repeat (gap_len) begin @(posedge clk); #1; end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    total++; if (got !== 144'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", got); end
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, err}); end
  endtask

  task automatic test_basic();
    busy_cnt = 0;
    send_frame(f1, -1, 0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done_cycle got=%b exp=0", busy); end
    total++; if (busy_cnt != 17) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=17", busy_cnt); end
    total++;
    if ({in11, in21, in33} !== {16'h1234, 16'hDEF0, 16'h5555}) begin
      bad++; $display("FAIL basic_elems got=%h %h %h exp=1234 DEF0 5555", in11, in21, in33);
    end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b exp=0", done); end
  endtask

  task automatic test_gap();
    int e0;
    e0 = nerr;
    send_frame(f1, 5, 10);
    @(posedge clk); #1;
    total++; if (nerr != e0) begin bad++; $display("FAIL gap_err got=%0d exp=%0d", nerr, e0); end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = ndone;
    send_frame(f1, -1, 0);
    send_frame(fa, -1, 0);
    @(posedge clk); #1;
    total++; if (ndone - d0 != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", ndone - d0); end
    total++; if (done_cyc - prev_done_cyc != 18) begin bad++; $display("FAIL b2b_spacing got=%0d exp=18", done_cyc - prev_done_cyc); end
    total++; if (got !== {9{16'hAAAA}}) begin bad++; $display("FAIL b2b_final got=%h exp=all AAAA", got); end
  endtask

  task automatic test_timeout();
    int e0;
    logic [143:0] keep;
    keep = last_good;
    e0 = nerr;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; serial_in = 8'(k + 8'h40);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (63) begin @(posedge clk); #1; end
    total++; if ({busy, err} !== 2'b10) begin bad++; $display("FAIL timeout_early got=%b exp=10", {busy, err}); end
    @(posedge clk); #1;
    total++; if ({busy, err} !== 2'b01) begin bad++; $display("FAIL timeout_fire got=%b exp=01", {busy, err}); end
    total++; if (got !== keep) begin bad++; $display("FAIL timeout_hold got=%h exp=%h", got, keep); end
    @(posedge clk); #1;
    total++; if (nerr - e0 != 1) begin bad++; $display("FAIL timeout_err_count got=%0d exp=1", nerr - e0); end
    for (int k = 0; k < 18; k++) fr[k] = 8'($urandom_range(0, 255));
    send_frame(fr, -1, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    int d0;
    d0 = ndone;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1; serial_in = 8'hC0 + 8'(k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (got !== 144'd0) begin bad++; $display("FAIL rstmid_outputs got=%h exp=0", got); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rstmid_flags got=%b exp=00", {busy, done}); end
    @(posedge clk); #1;
    total++; if (ndone != d0) begin bad++; $display("FAIL rstmid_done got=%0d exp=%0d", ndone, d0); end
    for (int k = 0; k < 18; k++) fr[k] = 8'(k * 13 + 7);
    send_frame(fr, -1, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_rst_valid();
    int d0;
    d0 = ndone;
    rst = 1'b1; in_valid = 1'b1; serial_in = 8'hFF;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstvalid_busy got=%b exp=0", busy); end
    total++; if (got !== 144'd0) begin bad++; $display("FAIL rstvalid_outputs got=%h exp=0", got); end
    repeat (20) @(posedge clk); #1;
    total++; if (ndone != d0) begin bad++; $display("FAIL rstvalid_done got=%0d exp=%0d", ndone, d0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_back_to_back();
    test_timeout();
    test_rst_mid();
    test_rst_valid();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    total++; if (ndone != 6) begin bad++; $display("FAIL done_total got=%0d exp=6", ndone); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
